handshake_rr_ctrl_arbiter: RTL and testbench
============================================

# handshake_rr_ctrl_arbiter

Round-robin arbiter that shares one downstream handshake resource, such as a constant generator or shared operator, among NUM_INPUTS control-only requesters. Each cycle it grants at most one valid requester and consumes that requester's token. It emits the winner's index on a registered output channel, so the consumer can steer the shared resource's result back to the correct branch. It sits between the control branches of a dataflow circuit and the ctrl channel of the shared unit, and provides fair, deadlock-free sequencing with one-cycle latency and full throughput.

## Interface
- NUM_INPUTS, 4, number of requesting control channels; legal range 2..16.
- INDEX_WIDTH, $clog2(NUM_INPUTS), width of the winner index; derived, never overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- ins_valid  input  NUM_INPUTS  per-requester token valid.
- ins_ready  output  NUM_INPUTS  per-requester accept; at most one bit high per cycle.
- outs  output  INDEX_WIDTH  index of the granted requester.
- outs_valid  output  1  output token present.
- outs_ready  input  1  downstream accept.

## Operation
- Output is a one-entry register slot holding the fields outs and outs_valid.
- The slot can load when it is empty or when it is draining in the same cycle: load_en = !outs_valid || outs_ready.
- Arbitration:
  - Scan ins_valid circularly, starting at pointer ptr and wrapping from NUM_INPUTS-1 to 0.
  - The first valid requester found is the winner w.
  - If no requester is valid, there is no grant.
- Grant:
  - ins_ready[w] = load_en and the grant exists.
  - All other ins_ready bits are 0.
  - ins_ready is combinational from ins_valid, ptr, outs_valid and outs_ready.
- On a grant edge:
  - outs <= w.
  - outs_valid <= 1.
  - ptr <= (w == NUM_INPUTS-1) ? 0 : w+1.
- On a drain edge with no grant: outs_valid <= 0, and outs holds its last value.
- While outs_valid=1 and outs_ready=0:
  - outs and outs_valid stay stable.
  - ptr does not change.
  - All ins_ready bits are 0.
- A requester that is not granted keeps its valid high. The arbiter never drops or duplicates a token.
- Fairness: a requester that holds valid is granted within NUM_INPUTS grants.
- When NUM_INPUTS is not a power of 2, index codes of NUM_INPUTS or more never appear on outs.

## Timing
- Reset (rst=0, asynchronous):
  - outs_valid=0, outs=0, ptr=0.
  - ins_ready forced to all-0 for as long as rst=0.
- Reset asserted mid-operation discards any pending slot token. The first grant after release starts scanning from index 0.
- Latency: a token accepted on edge k appears on outs/outs_valid right after edge k.
- Throughput: one grant per cycle while outs_ready=1.
- Simultaneous drain and load in one cycle is legal. outs_valid stays 1 and outs takes the new winner.
- outs_ready is never combinationally forwarded to outs_valid. outs_valid is purely registered.
- Combinational path: outs_ready to ins_ready. No path from ins_valid to outs_valid.

## Structure
- Shared package handshake_pkg:
  - Contains the index-width helper function (clog2 with a minimum of 1).
  - Contains the typedef for the one-hot grant vector, which other handshake arbiters and merges reuse.
- Sub-module rr_priority_picker:
  - Purely combinational.
  - Inputs: req vector and ptr. Outputs: one-hot grant, encoded index, any-valid.
  - Implemented as a double-width rotate plus priority encode.
- The top level holds ptr, the output slot register and the ready gating.

## Test plan
- Reset and idle:
  - Hold rst=0 for 3 cycles with ins_valid=4'b1111. Required: ins_ready=0, outs_valid=0, outs=0 throughout.
  - Release rst. Required: the first output is outs=0.
- Full contention, NUM_INPUTS=4:
  - ins_valid=4'b1111 held, outs_ready=1.
  - Required: outs sequence 0,1,2,3,0,1 on consecutive cycles, exactly one ins_ready bit high per cycle.
- Backpressure:
  - Token outs=2 is pending, then hold outs_ready=0 for 5 cycles.
  - Required: outs=2 and outs_valid=1 stable, ins_ready=0, ptr unchanged.
  - Raise outs_ready. Required: the next grant is 3 if it is valid.
- Wrap-around with a sparse request:
  - Set ptr=3 (by granting 2), then ins_valid=4'b0011.
  - Required: grant 0, then 1, then 0.
- Non-power-of-2, NUM_INPUTS=3:
  - All requesters valid for 7 grants. Required: 0,1,2,0,1,2,0; code 3 never appears.
- Asynchronous reset mid-stream:
  - Assert rst between edges while outs_valid=1. Required: outs_valid drops immediately without waiting for a clock edge.
  - After release with all requesters valid, the first outs=0.

Source files
------------

// File: rtl/handshake_pkg.sv
// handshake_pkg: helpers and shared types for the
// handshake arbiters and merges.
package handshake_pkg;

    localparam int MAX_INPUTS = 16;

    typedef logic [MAX_INPUTS-1:0] onehot_t;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational circular priority search
// starting at ptr; returns one-hot grant, index and any-valid.
module rr_priority_picker
    import handshake_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         any
);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;
    logic         hit;
    onehot_t      oh;

    always_comb begin
        // rotating the doubled vector puts req[ptr] at bit 0
        rot = N'({req, req} >> ptr);
        hit = 1'b0;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                off = W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end
        index = sum[W-1:0];
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = hit && (index == W'(i));
        end
    end

    assign grant = oh[N-1:0];
    assign any   = |oh;

endmodule

// File: rtl/handshake_rr_ctrl_arbiter.sv
// handshake_rr_ctrl_arbiter: round-robin grant of control tokens
// onto a registered winner-index output channel.
module handshake_rr_ctrl_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int INDEX_WIDTH = idx_width(NUM_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic [INDEX_WIDTH-1:0] outs,
    output logic                   outs_valid,
    input  logic                   outs_ready
);

    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] win;
    logic [NUM_INPUTS-1:0]  grant;
    logic                   any;
    logic                   load_en;
    logic                   take;

    rr_priority_picker #(
        .N(NUM_INPUTS),
        .W(INDEX_WIDTH)
    ) u_pick (
        .req  (ins_valid),
        .ptr  (ptr),
        .grant(grant),
        .index(win),
        .any  (any)
    );

    assign load_en   = !outs_valid || outs_ready;
    // rst gates ready so no token is consumed while held in reset
    assign take      = rst && load_en && any;
    assign ins_ready = take ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_valid <= 1'b0;
            outs       <= '0;
            ptr        <= '0;
        end else if (load_en) begin
            outs_valid <= any;
            if (any) begin
                outs <= win;
                ptr  <= (win == INDEX_WIDTH'(NUM_INPUTS - 1))
                        ? '0 : win + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_rr_ctrl_arbiter.sv
// tb_handshake_rr_ctrl_arbiter: scoreboard bench with a
// token-level round-robin reference model.
module tb_handshake_rr_ctrl_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] ins_valid = '0;
    logic [N-1:0] ins_ready;
    logic [1:0]   outs;
    logic         outs_valid;
    logic         outs_ready = 1'b0;

    logic         rst3 = 1'b0;
    logic [2:0]   ins_valid3 = 3'b111;
    logic [2:0]   ins_ready3;
    logic [1:0]   outs3;
    logic         outs_valid3;
    logic         outs_ready3 = 1'b1;

    int checks = 0;
    int fails  = 0;
    int expq[$];
    bit mon_en = 1'b0;
    int start  = 0;
    bit [N-1:0] pending = '0;
    int waitcnt[N];

    always #5 clk = ~clk;

    handshake_rr_ctrl_arbiter #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .outs      (outs),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    handshake_rr_ctrl_arbiter #(.NUM_INPUTS(3)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .ins_valid (ins_valid3),
        .ins_ready (ins_ready3),
        .outs      (outs3),
        .outs_valid(outs_valid3),
        .outs_ready(outs_ready3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: add new tokens, decide the expected winner,
    // then record the grant at the clock edge.
    task automatic step(input bit rdy, input bit [N-1:0] add,
                        output int w);
        bit full;
        bit load;
        int exp_ready;
        @(negedge clk);
        pending    = pending | add;
        ins_valid  = pending;
        outs_ready = rdy;
        #1;
        full = (expq.size() != 0);
        load = !full || rdy;
        w = -1;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pending[(start + k) % N]) begin
                    w = (start + k) % N;
                end
            end
        end
        exp_ready = (w >= 0) ? (1 << w) : 0;
        check("ins_ready", int'(ins_ready), exp_ready);
        if (w >= 0) begin
            check("fairness", int'(waitcnt[w] < N), 1);
        end
        @(posedge clk);
        if (w >= 0) begin
            expq.push_back(w);
            pending[w] = 1'b0;
            waitcnt[w] = 0;
            for (int i = 0; i < N; i++) begin
                if (pending[i]) waitcnt[i]++;
            end
            start = (w + 1) % N;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            check("outs_valid", int'(outs_valid), int'(expq.size() != 0));
            if (expq.size() != 0) begin
                check("outs", int'(outs), expq[0]);
                if (outs_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int fc[6]   = '{0, 1, 2, 3, 0, 1};
        int seq3[7] = '{0, 1, 2, 0, 1, 2, 0};
        for (int i = 0; i < N; i++) waitcnt[i] = 0;

        pending   = '1;
        ins_valid = pending;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_ins_ready", int'(ins_ready), 0);
            check("rst_outs_valid", int'(outs_valid), 0);
            check("rst_outs", int'(outs), 0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) begin
            step(1'b1, '1, w);
            check("contention", w, fc[k]);
        end

        step(1'b1, '1, w);
        check("bp_load", w, 2);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '1, w);
            check("bp_no_grant", w, -1);
        end
        step(1'b1, '1, w);
        check("bp_next", w, 3);

        for (int k = 0; k < 10 && pending != 0; k++) step(1'b1, '0, w);
        check("drained", int'(pending), 0);
        step(1'b1, '0, w);
        step(1'b1, 4'b0100, w);
        check("wrap_setup", w, 2);
        step(1'b1, 4'b0011, w);
        check("wrap_0", w, 0);
        step(1'b1, 4'b0000, w);
        check("wrap_1", w, 1);
        step(1'b1, 4'b0001, w);
        check("wrap_2", w, 0);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom() & $urandom()), w);
        end

        step(1'b1, '1, w);
        @(negedge clk);
        #3;
        check("pre_reset_valid", int'(outs_valid), 1);
        rst    = 1'b0;
        mon_en = 1'b0;
        #1;
        check("async_outs_valid", int'(outs_valid), 0);
        check("async_outs", int'(outs), 0);
        check("async_ins_ready", int'(ins_ready), 0);
        expq.delete();
        start   = 0;
        pending = '1;
        ins_valid = pending;
        for (int i = 0; i < N; i++) waitcnt[i] = 0;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        step(1'b1, '1, w);
        check("after_async", w, 0);
        step(1'b1, '1, w);
        check("after_async_next", w, 1);

        @(negedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b0;

        @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            check("n3_valid", int'(outs_valid3), 1);
            check("n3_outs", int'(outs3), seq3[k]);
            check("n3_onehot", int'($onehot(ins_ready3)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
